// File: rtl/pmod_cls_line_sequencer.sv
// PmodCLS line sequencer: after the power-on boot delay, each update request
// sends clear, cursor row 0, line 1, cursor row 1 and line 2 to the SPI-solo
// driver. A fixed idle gap follows each transaction.
module pmod_cls_line_sequencer #(
    parameter int PARAM_BOOT_CYCLES = 2000000,
    parameter int PARAM_GAP_CYCLES  = 2000
) (
    input  logic         i_clk_20mhz,
    input  logic         i_rst_20mhz,
    input  logic         i_update_req,
    input  logic [127:0] i_line1,
    input  logic [127:0] i_line2,
    output logic         o_ready,
    output logic         o_seq_done,
    output logic [7:0]   o_tx_data,
    output logic         o_tx_enqueue,
    input  logic         i_tx_ready,
    output logic         o_go_stand,
    output logic [5:0]   o_tx_len,
    input  logic         i_spi_idle
);

    localparam int CNT_MAX = (PARAM_BOOT_CYCLES > PARAM_GAP_CYCLES) ? PARAM_BOOT_CYCLES : PARAM_GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT_BUSY,
        ST_WAIT_IDLE,
        ST_GAP
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         step;
    logic [4:0]         byte_idx;
    logic               pending;
    logic               pending_next;
    logic               ready_q;
    logic [127:0]       shadow_line1;
    logic [127:0]       shadow_line2;
    logic [127:0]       work_line1;
    logic [127:0]       work_line2;
    logic [7:0]         cur_byte;
    logic [4:0]         step_len;
    logic [3:0]         char_sel;
    logic               cnt_done;
    logic               last_byte;
    logic               accept;

    assign char_sel  = 4'd15 - byte_idx[3:0];
    assign last_byte = (byte_idx == (step_len - 5'd1));
    assign accept    = (state == ST_LOAD) && i_tx_ready;
    assign cnt_done  = (state == ST_BOOT) ? (cnt == CNT_W'(PARAM_BOOT_CYCLES - 1))
                                          : (cnt == CNT_W'(PARAM_GAP_CYCLES - 1));
    // A new request always wins over the IDLE consume, so a request landing on
    // the launch cycle stays queued for the next sequence.
    assign pending_next = i_update_req ? 1'b1 : ((state == ST_IDLE) ? 1'b0 : pending);
    assign o_ready = ready_q;

    // Cursor-positioning escape sequence "ESC [ row ; 0 H".
    function automatic logic [7:0] cursor_byte(input logic [4:0] idx, input logic [7:0] row);
        case (idx)
            5'd0:    cursor_byte = 8'h1b;
            5'd1:    cursor_byte = 8'h5b;
            5'd2:    cursor_byte = row;
            5'd3:    cursor_byte = 8'h3b;
            5'd4:    cursor_byte = 8'h30;
            default: cursor_byte = 8'h48;
        endcase
    endfunction

    // Select the current step's length and the byte at the current index.
    always_comb begin
        cur_byte = 8'h00;
        step_len = 5'd0;
        case (step)
            3'd0: begin
                step_len = 5'd3;
                case (byte_idx)
                    5'd0:    cur_byte = 8'h1b;
                    5'd1:    cur_byte = 8'h5b;
                    default: cur_byte = 8'h6a;
                endcase
            end
            3'd1: begin
                step_len = 5'd6;
                cur_byte = cursor_byte(byte_idx, 8'h30);
            end
            3'd2: begin
                step_len = 5'd16;
                cur_byte = work_line1[{char_sel, 3'b000} +: 8];
            end
            3'd3: begin
                step_len = 5'd6;
                cur_byte = cursor_byte(byte_idx, 8'h31);
            end
            3'd4: begin
                step_len = 5'd16;
                cur_byte = work_line2[{char_sel, 3'b000} +: 8];
            end
            default: begin
                step_len = 5'd1;
                cur_byte = 8'h00;
            end
        endcase
    end

    // State register; reset aborts whatever step is in flight.
    always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
        if (i_rst_20mhz) begin
            state <= ST_BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and the handshake outputs driven by each state.
    always_comb begin
        state_next   = state;
        o_tx_enqueue = 1'b0;
        o_tx_data    = 8'h00;
        o_go_stand   = 1'b0;
        o_tx_len     = 6'd0;
        o_seq_done   = 1'b0;
        case (state)
            ST_BOOT: begin
                if (cnt_done) state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (pending) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                o_tx_enqueue = 1'b1;
                o_tx_data    = cur_byte;
                if (i_tx_ready && last_byte) state_next = ST_START;
            end
            ST_START: begin
                o_go_stand = 1'b1;
                o_tx_len   = {1'b0, step_len};
                state_next = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!i_spi_idle) state_next = ST_WAIT_IDLE;
            end
            ST_WAIT_IDLE: begin
                if (i_spi_idle) state_next = ST_GAP;
            end
            ST_GAP: begin
                if (cnt_done) begin
                    if (step < 3'd4) begin
                        state_next = ST_LOAD;
                    end else begin
                        o_seq_done = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_BOOT;
        endcase
    end

    // Boot/gap counter runs only in BOOT and GAP and restarts on every state change.
    always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
        if (i_rst_20mhz) begin
            cnt <= '0;
        end else if (state_next != state) begin
            cnt <= '0;
        end else if ((state == ST_BOOT) || (state == ST_GAP)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Step and byte-index bookkeeping; the index only moves on an accepted byte.
    always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
        if (i_rst_20mhz) begin
            step     <= 3'd0;
            byte_idx <= 5'd0;
        end else begin
            if ((state == ST_IDLE) && pending) begin
                step <= 3'd0;
            end else if ((state == ST_GAP) && cnt_done && (step < 3'd4)) begin
                step <= step + 3'd1;
            end
            if (accept) begin
                byte_idx <= last_byte ? 5'd0 : (byte_idx + 5'd1);
            end
        end
    end

    // Request capture into the shadow, working copy at launch, registered ready.
    always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
        if (i_rst_20mhz) begin
            pending      <= 1'b0;
            ready_q      <= 1'b0;
            shadow_line1 <= '0;
            shadow_line2 <= '0;
            work_line1   <= '0;
            work_line2   <= '0;
        end else begin
            pending <= pending_next;
            ready_q <= (state_next == ST_IDLE) && !pending_next;
            if (i_update_req) begin
                shadow_line1 <= i_line1;
                shadow_line2 <= i_line2;
            end
            if ((state == ST_IDLE) && pending) begin
                work_line1 <= shadow_line1;
                work_line2 <= shadow_line2;
            end
        end
    end

endmodule

// File: tb/tb_pmod_cls_line_sequencer.sv
// Self-checking bench for pmod_cls_line_sequencer: table vectors, random lines
// against a stream-level reference model, and hand-written corner sequences.
module tb_pmod_cls_line_sequencer;

    localparam int BOOT = 50;
    localparam int GAP  = 10;

    logic         clk;
    logic         rst;
    logic         update_req;
    logic [127:0] line1;
    logic [127:0] line2;
    logic         ready;
    logic         seq_done;
    logic [7:0]   tx_data;
    logic         tx_enqueue;
    logic         tx_ready;
    logic         go_stand;
    logic [5:0]   tx_len;
    logic         spi_idle;

    pmod_cls_line_sequencer #(
        .PARAM_BOOT_CYCLES(BOOT),
        .PARAM_GAP_CYCLES(GAP)
    ) dut (
        .i_clk_20mhz (clk),
        .i_rst_20mhz (rst),
        .i_update_req(update_req),
        .i_line1     (line1),
        .i_line2     (line2),
        .o_ready     (ready),
        .o_seq_done  (seq_done),
        .o_tx_data   (tx_data),
        .o_tx_enqueue(tx_enqueue),
        .i_tx_ready  (tx_ready),
        .o_go_stand  (go_stand),
        .o_tx_len    (tx_len),
        .i_spi_idle  (spi_idle)
    );

    typedef struct {
        logic [127:0] l1;
        logic [127:0] l2;
        int           bp_mode;
        int           busy;
        logic [7:0]   exp_char0;
        logic [7:0]   exp_last;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;
    int done_count = 0;
    int first_enq_cyc = -1;
    int last_idle_rise = -1;
    int ready_boot_hits = 0;
    bit boot_watch = 0;
    bit drv_respond = 1;
    int busy_len = 20;
    int bp_mode = 0;
    int busy_cnt = 0;
    bit stall_prev = 0;
    logic [7:0] stall_data = 8'h00;
    bit idle_prev = 1;
    logic [7:0] got_bytes[$];
    logic [7:0] exp_bytes[$];
    int got_lens[$];
    int exp_lens[$];

    initial clk = 1'b0;
    always #25 clk = ~clk;

    // Cycle count since the last reset release, used for timing checks.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic checkOutput(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) tick();
    endtask

    task automatic applyStimulus(input logic [127:0] l1, input logic [127:0] l2);
        line1 = l1;
        line2 = l2;
        update_req = 1'b1;
        tick();
        update_req = 1'b0;
    endtask

    task automatic waitDone(input int target, input int budget);
        int n = 0;
        while (done_count < target && n < budget) begin
            tick();
            n++;
        end
        checkOutput("seq_done_timeout", int'(done_count >= target), 1);
    endtask

    task automatic clearQueues();
        got_bytes.delete();
        exp_bytes.delete();
        got_lens.delete();
        exp_lens.delete();
    endtask

    // Reference: a sequence is the clear command, two cursor commands and the raw lines.
    task automatic buildStream(input logic [127:0] l1, input logic [127:0] l2);
        logic [7:0] hdr [0:2];
        hdr = '{8'h1b, 8'h5b, 8'h6a};
        foreach (hdr[i]) exp_bytes.push_back(hdr[i]);
        exp_lens.push_back(3);
        for (int r = 0; r < 2; r++) begin
            logic [127:0] ln;
            exp_bytes.push_back(8'h1b);
            exp_bytes.push_back(8'h5b);
            exp_bytes.push_back(8'h30 + 8'(r));
            exp_bytes.push_back(8'h3b);
            exp_bytes.push_back(8'h30);
            exp_bytes.push_back(8'h48);
            exp_lens.push_back(6);
            ln = (r == 0) ? l1 : l2;
            for (int c = 0; c < 16; c++) exp_bytes.push_back(ln[127 - 8*c -: 8]);
            exp_lens.push_back(16);
        end
    endtask

    task automatic compareStreams(input string tag);
        int nb;
        int nl;
        checkOutput({tag, "_byte_count"}, got_bytes.size(), exp_bytes.size());
        checkOutput({tag, "_go_count"}, got_lens.size(), exp_lens.size());
        nb = (got_bytes.size() < exp_bytes.size()) ? got_bytes.size() : exp_bytes.size();
        nl = (got_lens.size() < exp_lens.size()) ? got_lens.size() : exp_lens.size();
        for (int i = 0; i < nb; i++)
            checkOutput($sformatf("%s_byte%0d", tag, i), int'(got_bytes[i]), int'(exp_bytes[i]));
        for (int i = 0; i < nl; i++)
            checkOutput($sformatf("%s_len%0d", tag, i), got_lens[i], exp_lens[i]);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ready"}, int'(ready), 0);
        checkOutput({tag, "_seq_done"}, int'(seq_done), 0);
        checkOutput({tag, "_tx_data"}, int'(tx_data), 0);
        checkOutput({tag, "_tx_enqueue"}, int'(tx_enqueue), 0);
        checkOutput({tag, "_go_stand"}, int'(go_stand), 0);
        checkOutput({tag, "_tx_len"}, int'(tx_len), 0);
    endtask

    function automatic logic [127:0] randomLine();
        logic [127:0] l;
        for (int c = 0; c < 16; c++) l[127 - 8*c -: 8] = 8'($urandom_range(32, 126));
        return l;
    endfunction

    // SPI driver model: goes busy for busy_len cycles after each go pulse; also drives FIFO ready.
    initial begin
        spi_idle = 1'b1;
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) spi_idle = 1'b1;
            end else if (go_stand && drv_respond) begin
                busy_cnt = busy_len;
                spi_idle = 1'b0;
            end
            if (bp_mode == 1 && (got_lens.size() % 5) == 2) tx_ready = ~tx_ready;
            else if (bp_mode == 2) tx_ready = 1'($urandom_range(0, 1));
            else tx_ready = 1'b1;
        end
    end

    // Monitor: collects accepted bytes and go lengths, checks stall hold and go spacing.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 0;
            end else begin
                if (stall_prev) begin
                    checkOutput("stall_hold_enqueue", int'(tx_enqueue), 1);
                    checkOutput("stall_hold_data", int'(tx_data), int'(stall_data));
                end
                stall_prev = tx_enqueue && !tx_ready;
                stall_data = tx_data;
                if (tx_enqueue && tx_ready) begin
                    got_bytes.push_back(tx_data);
                    if (first_enq_cyc < 0) first_enq_cyc = cyc;
                end
                if (go_stand) begin
                    got_lens.push_back(int'(tx_len));
                    if (last_idle_rise >= 0)
                        checkOutput("go_gap_after_idle", int'((cyc - last_idle_rise) >= GAP), 1);
                end
                if (seq_done) done_count++;
                if (boot_watch && ready) ready_boot_hits++;
                if (spi_idle && !idle_prev) last_idle_rise = cyc;
                idle_prev = spi_idle;
            end
        end
    end

    initial begin
        vec_t vecs [0:2];
        int d0;
        int n;
        logic [127:0] hello;
        logic [127:0] digits;
        logic [127:0] l_a;
        logic [127:0] l_b;

        hello  = "HELLO WORLD     ";
        digits = "0123456789ABCDEF";
        l_a    = "AAAAAAAAAAAAAAAA";
        l_b    = "BBBBBBBBBBBBBBBB";
        vecs[0] = '{hello, digits, 0, 20, 8'h48, 8'h46};
        vecs[1] = '{hello, digits, 1, 20, 8'h48, 8'h46};
        vecs[2] = '{"zyxwvutsrqponmlk", "Line two ~!@#$%^", 1, 3, 8'h7a, 8'h5e};

        rst = 1'b1;
        update_req = 1'b0;
        line1 = '0;
        line2 = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Boot with a request at cycle 5
        clearQueues();
        boot_watch = 1;
        n = 0;
        while (cyc < 5 && n < 100) begin tick(); n++; end
        applyStimulus(hello, digits);
        buildStream(hello, digits);
        waitDone(1, 3000);
        boot_watch = 0;
        checkOutput("boot_first_enqueue_cycle", int'(first_enq_cyc >= BOOT), 1);
        checkOutput("boot_ready_low", ready_boot_hits, 0);
        compareStreams("boot");
        tick();
        checkOutput("boot_ready_after_done", int'(ready), 1);
        checkOutput("boot_done_pulses", done_count, 1);

        // Table-driven vectors
        for (int v = 0; v < 3; v++) begin
            clearQueues();
            bp_mode = vecs[v].bp_mode;
            busy_len = vecs[v].busy;
            d0 = done_count;
            buildStream(vecs[v].l1, vecs[v].l2);
            applyStimulus(vecs[v].l1, vecs[v].l2);
            checkOutput($sformatf("vec%0d_ready_drop", v), int'(ready), 0);
            waitDone(d0 + 1, 3000);
            tick();
            checkOutput($sformatf("vec%0d_ready_after", v), int'(ready), 1);
            compareStreams($sformatf("vec%0d", v));
            checkOutput($sformatf("vec%0d_char0", v), int'(got_bytes[9]), int'(vecs[v].exp_char0));
            checkOutput($sformatf("vec%0d_last", v), int'(got_bytes[46]), int'(vecs[v].exp_last));
        end

        // Queued requests: one overwritten in-flight request yields one extra sequence
        clearQueues();
        bp_mode = 0;
        busy_len = 20;
        d0 = done_count;
        buildStream(hello, digits);
        applyStimulus(hello, digits);
        n = 0;
        while (got_bytes.size() < 4 && n < 1000) begin tick(); n++; end
        checkOutput("queued_reach_step1", int'(got_bytes.size() >= 4), 1);
        applyStimulus(l_a, digits);
        n = 0;
        while (got_bytes.size() < 27 && n < 1000) begin tick(); n++; end
        checkOutput("queued_reach_step3", int'(got_bytes.size() >= 27), 1);
        applyStimulus(l_b, digits);
        buildStream(l_b, digits);
        waitDone(d0 + 2, 4000);
        waitCycles(400);
        checkOutput("queued_done_pulses", done_count - d0, 2);
        checkOutput("queued_ready_idle", int'(ready), 1);
        compareStreams("queued");

        // Randomized lines, timing and backpressure against the stream model
        for (int r = 0; r < 5; r++) begin
            logic [127:0] a1;
            logic [127:0] a2;
            int nreq;
            clearQueues();
            bp_mode = 2;
            busy_len = $urandom_range(1, 30);
            d0 = done_count;
            a1 = randomLine();
            a2 = randomLine();
            buildStream(a1, a2);
            applyStimulus(a1, a2);
            nreq = 1;
            if ($urandom_range(0, 1) == 1) begin
                waitCycles($urandom_range(2, 60));
                a1 = randomLine();
                a2 = randomLine();
                buildStream(a1, a2);
                applyStimulus(a1, a2);
                nreq = 2;
            end
            waitDone(d0 + nreq, 6000);
            tick();
            compareStreams($sformatf("rand%0d", r));
        end
        bp_mode = 0;

        // Reset while step 2 is waiting for the driver to return idle
        clearQueues();
        busy_len = 20;
        applyStimulus(hello, digits);
        n = 0;
        while (got_lens.size() < 3 && n < 2000) begin tick(); n++; end
        checkOutput("midrst_reach_step2_go", got_lens.size(), 3);
        n = 0;
        while (spi_idle && n < 10) begin tick(); n++; end
        waitCycles(3);
        #5;
        rst = 1'b1;
        #1;
        checkAllZero("midrst");
        tick();
        rst = 1'b0;
        clearQueues();
        d0 = done_count;
        waitCycles(20);
        checkOutput("midrst_ready_in_boot", int'(ready), 0);
        waitCycles(400);
        checkOutput("midrst_no_bytes", got_bytes.size(), 0);
        checkOutput("midrst_no_go", got_lens.size(), 0);
        checkOutput("midrst_no_done", done_count - d0, 0);
        checkOutput("midrst_ready_after_boot", int'(ready), 1);

        // Stuck driver: never goes busy, sequence must hang in WAIT_BUSY
        clearQueues();
        drv_respond = 0;
        d0 = done_count;
        applyStimulus(hello, digits);
        n = 0;
        while (got_lens.size() < 1 && n < 200) begin tick(); n++; end
        waitCycles(300);
        checkOutput("stuck_go_count", got_lens.size(), 1);
        checkOutput("stuck_byte_count", got_bytes.size(), 3);
        checkOutput("stuck_no_done", done_count - d0, 0);
        checkOutput("stuck_ready_low", int'(ready), 0);
        checkOutput("stuck_no_enqueue", int'(tx_enqueue), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pmod_cls_line_sequencer.md
Name: pmod_cls_line_sequencer

Overview:
- Sequences the PmodCLS character LCD through the standard SPI-solo driver.
- On each update request it sends these five SPI transactions in fixed order: clear display, cursor to row 0, 16 characters of line 1, cursor to row 1, 16 characters of line 2.
- It sits between application logic (which supplies two 16-character ASCII lines) and the SPI driver's TX FIFO / go handshake.
- It enforces a power-on boot delay and an inter-transaction gap.

Parameters:
- PARAM_BOOT_CYCLES, 2000000: cycles waited after reset before the first transaction (100 ms at 20 MHz).
- PARAM_GAP_CYCLES, 2000: idle cycles inserted after each transaction completes (100 us at 20 MHz).

Ports:
- i_clk_20mhz  in  1  system clock
- i_rst_20mhz  in  1  asynchronous, active-high reset
- i_update_req  in  1  single-cycle request to redraw both lines
- i_line1  in  128  line 1 ASCII; char 0 = bits [127:120]
- i_line2  in  128  line 2 ASCII; same byte order as i_line1
- o_ready  out  1  high when boot is done, the FSM is idle and no request is pending
- o_seq_done  out  1  one-cycle pulse when the line 2 transaction's gap expires
- o_tx_data  out  8  byte to the SPI driver TX FIFO
- o_tx_enqueue  out  1  TX FIFO write strobe; the byte is accepted when o_tx_enqueue and i_tx_ready are both high
- i_tx_ready  in  1  TX FIFO can accept a byte
- o_go_stand  out  1  one-cycle start pulse to the SPI driver
- o_tx_len  out  6  byte count of the transaction; valid while o_go_stand is high
- i_spi_idle  in  1  SPI driver idle

Behaviour:
- Reset (async assert, sync release):
  - State = BOOT; boot/gap counter = 0; step = 0; pending = 0.
  - All outputs 0, including o_ready.
- FSM states: BOOT, IDLE, LOAD, START, WAIT_BUSY, WAIT_IDLE, GAP.
- BOOT: counts PARAM_BOOT_CYCLES, then goes to IDLE. i_update_req during BOOT sets pending and captures both lines.
- Request capture:
  - i_update_req in any non-reset state sets pending and captures i_line1/i_line2 into shadow registers.
  - A later request overwrites the shadow before the sequence starts.
  - The active sequence uses a working copy taken at IDLE->LOAD.
  - A request arriving during a sequence is queued (one deep) and starts only after o_seq_done.
- IDLE: if pending, clear pending, copy shadow to working, set step = 0, go to LOAD.
- Steps and byte streams:
  - Step 0, len 3: 1b 5b 6a
  - Step 1, len 6: 1b 5b 30 3b 30 48
  - Step 2, len 16: working line 1, chars 0..15
  - Step 3, len 6: 1b 5b 31 3b 30 48
  - Step 4, len 16: working line 2, chars 0..15
- LOAD:
  - o_tx_enqueue is high with the current byte; the byte index advances only on accept.
  - i_tx_ready low stalls with data held stable.
  - After the last byte is accepted, go to START.
- START: o_go_stand = 1 and o_tx_len = step length for exactly one cycle, then WAIT_BUSY.
- WAIT_BUSY: wait for i_spi_idle = 0, then WAIT_IDLE.
- WAIT_IDLE: wait for i_spi_idle = 1, then GAP.
- GAP:
  - Count PARAM_GAP_CYCLES.
  - If step < 4: step += 1, go to LOAD.
  - Otherwise: pulse o_seq_done, go to IDLE.
- o_ready is registered: 1 only in IDLE with pending = 0; drops the cycle after a request is captured.
- No timeout: a driver that never goes busy holds the FSM in WAIT_BUSY indefinitely; only reset recovers.
- Reset mid-sequence:
  - Aborts immediately, discarding the current step and pending request.
  - No partial go pulse is issued; bytes already enqueued are the driver's responsibility.
- Counters are sized to hold the parameters; the byte index is 5 bits.

Test Plan:
- Boot:
  - Set PARAM_BOOT_CYCLES = 50, PARAM_GAP_CYCLES = 10; pulse i_update_req at cycle 5.
  - Required: no enqueue before cycle 50; o_ready stays 0 throughout; the sequence then starts automatically.
- Full sequence:
  - line1 = "HELLO WORLD     ", line2 = "0123456789ABCDEF".
  - Model the driver with i_spi_idle low for 20 cycles after each go pulse.
  - Required byte stream exactly: 1b 5b 6a | 1b 5b 30 3b 30 48 | 48 45 4c 4c 4f 20 57... | 1b 5b 31 3b 30 48 | 30 31...46.
  - o_tx_len pulses 3, 6, 16, 6, 16.
  - Each go pulse is at least 10 cycles after the previous idle return.
  - One o_seq_done pulse, then o_ready = 1.
- Backpressure:
  - Toggle i_tx_ready low every other cycle during step 2.
  - Required: all 16 bytes are delivered once each, in order, with no duplicates; o_tx_data is stable while stalled.
- Queued requests:
  - During step 1, pulse i_update_req with line1 = "AAAA..."; pulse again in step 3 with line1 = "BBBB...".
  - Required: the current sequence completes unchanged; exactly one further sequence runs, carrying the "BBBB..." line.
- Mid-sequence reset:
  - Assert i_rst_20mhz in WAIT_IDLE of step 2.
  - Required: all outputs 0 within the same cycle; after release, BOOT re-runs; no transaction occurs without a new request.
- Stuck driver:
  - Hold i_spi_idle = 1 after a go pulse.
  - Required: the FSM remains in WAIT_BUSY; no further go pulse or enqueue occurs.
